// File: rtl/aes256_decrypt_core.sv
// Iterative AES-256 inverse cipher: expands the 60-word key schedule one word per cycle,
// then applies one inverse round per cycle from round key 14 down to 0.
module aes256_decrypt_core (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [127:0] i_data_in,
    input  logic [255:0] i_key_in,
    output logic         o_busy,
    output logic         o_done,
    output logic [127:0] o_data_out
);
    localparam int ROUNDS = 14;
    localparam int NWORDS = 4 * (ROUNDS + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_KEYEXP   = 3'd1,
        S_INIT_ADD = 3'd2,
        S_ROUND    = 3'd3,
        S_FINAL    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
    endfunction

    function automatic logic [7:0] rcon(input logic [2:0] n);
        logic [7:0] v;
        case (n)
            3'd1:    v = 8'h01;
            3'd2:    v = 8'h02;
            3'd3:    v = 8'h04;
            3'd4:    v = 8'h08;
            3'd5:    v = 8'h10;
            3'd6:    v = 8'h20;
            3'd7:    v = 8'h40;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte (row r, column c) sits at index 4c+r; row r is rotated right by r.
    function automatic logic [127:0] inv_sub_shift(input logic [127:0] b);
        logic [127:0] y;
        y = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                y[127 - 8*(4*c + r) -: 8] = INV_SBOX[b[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8]];
            end
        end
        return y;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a, x2, x4, x8;
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a  = col[31 - 8*i -: 8];
            x2 = xtime(a);
            x4 = xtime(x2);
            x8 = xtime(x4);
            m9[i] = x8 ^ a;
            mb[i] = x8 ^ x2 ^ a;
            md[i] = x8 ^ x4 ^ a;
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] b);
        logic [127:0] y;
        y = 128'h0;
        for (int c = 0; c < 4; c++) begin
            y[127 - 32*c -: 32] = inv_mix_col(b[127 - 32*c -: 32]);
        end
        return y;
    endfunction

    state_t       r_state;
    state_t       w_state_next;
    logic [31:0]  r_w [NWORDS];
    logic [127:0] r_block;
    logic [5:0]   r_wcnt;
    logic [3:0]   r_rnd;
    logic [31:0]  w_prev;
    logic [31:0]  w_t;
    logic [31:0]  w_new_word;
    logic [127:0] w_rk;
    logic [127:0] w_sub_shift;
    logic [127:0] w_round;

    // Next key word, current round key and the inverse-round datapath.
    always_comb begin
        w_prev = r_w[r_wcnt - 6'd1];
        if (r_wcnt[2:0] == 3'd0) begin
            w_t = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon(r_wcnt[5:3]), 24'h000000};
        end else if (r_wcnt[2:0] == 3'd4) begin
            w_t = sub_word(w_prev);
        end else begin
            w_t = w_prev;
        end
        w_new_word  = r_w[r_wcnt - 6'd8] ^ w_t;
        w_rk        = {r_w[{r_rnd, 2'b00}], r_w[{r_rnd, 2'b01}], r_w[{r_rnd, 2'b10}], r_w[{r_rnd, 2'b11}]};
        w_sub_shift = inv_sub_shift(r_block);
        w_round     = inv_mix(w_sub_shift ^ w_rk);
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     w_state_next = i_start ? S_KEYEXP : S_IDLE;
            S_KEYEXP:   w_state_next = (r_wcnt == 6'd59) ? S_INIT_ADD : S_KEYEXP;
            S_INIT_ADD: w_state_next = S_ROUND;
            S_ROUND:    w_state_next = (r_rnd == 4'd1) ? S_FINAL : S_ROUND;
            S_FINAL:    w_state_next = S_DONE;
            S_DONE:     w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    // Key schedule, block and registered outputs; r_rnd starts at 14 so rk[r_rnd] serves INIT_ADD too.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < NWORDS; k++) begin
                r_w[k] <= 32'h0;
            end
            r_block    <= 128'h0;
            r_wcnt     <= 6'd8;
            r_rnd      <= 4'd0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_data_out <= 128'h0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_block <= i_data_in;
                        for (int k = 0; k < 8; k++) begin
                            r_w[k] <= i_key_in[255 - 32*k -: 32];
                        end
                        r_wcnt <= 6'd8;
                        r_rnd  <= 4'd14;
                        o_busy <= 1'b1;
                    end
                end
                S_KEYEXP: begin
                    r_w[r_wcnt] <= w_new_word;
                    r_wcnt      <= r_wcnt + 6'd1;
                end
                S_INIT_ADD: begin
                    r_block <= r_block ^ w_rk;
                    r_rnd   <= r_rnd - 4'd1;
                end
                S_ROUND: begin
                    r_block <= w_round;
                    r_rnd   <= r_rnd - 4'd1;
                end
                S_FINAL: o_data_out <= w_sub_shift ^ w_rk;
                S_DONE: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                end
                default: o_busy <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_aes256_decrypt_core.sv
// Bench for aes256_decrypt_core: ciphertexts come from a forward AES-256 model built from
// GF(2^8) arithmetic; a monitor pops expected plaintexts whenever done pulses.
module tb_aes256_decrypt_core;
    logic         clk;
    logic         i_rst;
    logic         i_start;
    logic [127:0] i_data_in;
    logic [255:0] i_key_in;
    logic         o_busy;
    logic         o_done;
    logic [127:0] o_data_out;

    int n_tests = 0;
    int n_fail  = 0;
    logic [127:0] exp_q [$];
    logic [7:0]   sb [256];
    logic [127:0] tx_ct  [3];
    logic [255:0] tx_key [3];
    logic [127:0] tx_pt  [3];

    aes256_decrypt_core dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_data_in  (i_data_in),
        .i_key_in   (i_key_in),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_data_out (o_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        logic [15:0] d;
        d = {b, b};
        return d[15 - k -: 8];
    endfunction

    // Forward S-box from multiplicative inverse plus affine map.
    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = 8'h63;
            for (int k = 0; k < 5; k++) s = s ^ rotl8(inv, k);
            sb[x] = s;
        end
    endtask

    function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [255:0] key);
        logic [7:0] w [240];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] tmp [4];
        logic [7:0] coef [4];
        logic [7:0] rc, acc, first;
        logic [127:0] out;
        coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        for (int i = 0; i < 32; i++) w[i] = key[255 - 8*i -: 8];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1) + j];
            if (i % 8 == 0) begin
                first = tmp[0];
                for (int j = 0; j < 3; j++) tmp[j] = tmp[j+1];
                tmp[3] = first;
                for (int j = 0; j < 4; j++) tmp[j] = sb[tmp[j]];
                tmp[0] = tmp[0] ^ rc;
                rc = gf_mul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                for (int j = 0; j < 4; j++) tmp[j] = sb[tmp[j]];
            end
            for (int j = 0; j < 4; j++) w[4*i + j] = w[4*(i-8) + j] ^ tmp[j];
        end
        for (int k = 0; k < 16; k++) s[k] = pt[127 - 8*k -: 8] ^ w[k];
        for (int r = 1; r <= 14; r++) begin
            for (int c = 0; c < 4; c++)
                for (int i = 0; i < 4; i++) t[4*c + i] = sb[s[4*((c + i) % 4) + i]];
            if (r < 14) begin
                for (int c = 0; c < 4; c++)
                    for (int i = 0; i < 4; i++) begin
                        acc = 8'h00;
                        for (int j = 0; j < 4; j++) acc = acc ^ gf_mul(coef[(j - i + 4) % 4], t[4*c + j]);
                        s[4*c + i] = acc;
                    end
            end else begin
                for (int k = 0; k < 16; k++) s[k] = t[k];
            end
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[16*r + k];
        end
        for (int k = 0; k < 16; k++) out[127 - 8*k -: 8] = s[k];
        return out;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic set_random_tx(input int idx);
        tx_pt[idx]  = rand128();
        tx_key[idx] = rand256();
        tx_ct[idx]  = model_encrypt(tx_pt[idx], tx_key[idx]);
    endtask

    task automatic set_c3_tx();
        tx_key[0] = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        tx_ct[0]  = 128'h8ea2b7ca516745bfeafc49904b496089;
        tx_pt[0]  = 128'h00112233445566778899aabbccddeeff;
    endtask

    // Scoreboard monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (o_done === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: done=1 with no outstanding transaction, data_out=%h", o_data_out);
            end else begin
                logic [127:0] e;
                e = exp_q.pop_front();
                if (o_data_out !== e) begin
                    n_fail++;
                    $display("FAIL result: data_out=%h expected=%h", o_data_out, e);
                end
            end
        end
    end

    // Drive inputs just after edge En for the following edge.
    task automatic drive_after(input int n, input int ntx, input bit pulses);
        int idx;
        idx = n / 69 + 1;
        if (n % 69 == 0 && idx < ntx) begin
            i_start   = 1'b1;
            i_data_in = tx_ct[idx];
            i_key_in  = tx_key[idx];
            exp_q.push_back(tx_pt[idx]);
        end else if (idx < ntx) begin
            i_start = 1'b1;
        end else begin
            i_start = pulses && (n + 1 == 10 || n + 1 == 40 || n + 1 == 68);
            if (n % 69 == 0) begin
                i_data_in = rand128();
                i_key_in  = rand256();
            end
        end
    endtask

    // Runs ntx transactions with start held across them; checks busy/done on every cycle.
    task automatic run_seq(input string name, input int ntx, input bit pulses);
        int last, bad, bad_n;
        logic eb, ed, bb, bd, xb, xd;
        last = 69 * ntx;
        bad = 0; bad_n = 0; bb = 1'b0; bd = 1'b0; xb = 1'b0; xd = 1'b0;
        @(negedge clk);
        i_start   = 1'b1;
        i_data_in = tx_ct[0];
        i_key_in  = tx_key[0];
        exp_q.push_back(tx_pt[0]);
        @(posedge clk); #1;
        drive_after(0, ntx, pulses);
        for (int n = 1; n <= last; n++) begin
            @(posedge clk); #1;
            eb = (n % 69 != 68) && (n < last);
            ed = (n % 69 == 68);
            if (o_busy !== eb || o_done !== ed) begin
                if (bad == 0) begin
                    bad_n = n; bb = o_busy; bd = o_done; xb = eb; xd = ed;
                end
                bad++;
            end
            drive_after(n, ntx, pulses);
        end
        i_start = 1'b0;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s_timing: %0d bad cycles, first at E%0d busy=%b done=%b, required busy=%b done=%b",
                     name, bad, bad_n, bb, bd, xb, xd);
        end
    endtask

    task automatic run_abort();
        int bad;
        @(negedge clk);
        i_start   = 1'b1;
        i_data_in = tx_ct[0];
        i_key_in  = tx_key[0];
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (30) @(posedge clk);
        #3;
        i_rst = 1'b1;
        #1;
        n_tests++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_data_out !== 128'h0) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b done=%b data_out=%h, required 0 0 0", o_busy, o_done, o_data_out);
        end
        @(negedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        bad = 0;
        for (int n = 0; n < 80; n++) begin
            @(posedge clk); #1;
            if (o_busy !== 1'b0 || o_done !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL quiet_after_reset: %0d cycles with busy/done high, required 0", bad);
        end
    endtask

    initial begin
        i_rst     = 1'b1;
        i_start   = 1'b0;
        i_data_in = 128'h0;
        i_key_in  = 256'h0;
        build_sbox();
        repeat (3) @(posedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        #1;
        n_tests++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_data_out !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b data_out=%h, required 0 0 0", o_busy, o_done, o_data_out);
        end

        set_c3_tx();
        run_seq("c3", 1, 1'b0);

        set_random_tx(0);
        run_seq("ignored_starts", 1, 1'b1);

        set_c3_tx();
        run_seq("c3_before_abort", 1, 1'b0);
        run_abort();
        run_seq("c3_after_abort", 1, 1'b0);

        for (int k = 0; k < 3; k++) set_random_tx(k);
        run_seq("held_start", 3, 1'b0);

        tx_key[0] = 256'h0;
        tx_ct[0]  = 128'hdc95c078a2408989ad48a21492842087;
        tx_pt[0]  = 128'h0;
        run_seq("zero_key", 1, 1'b0);

        for (int k = 0; k < 50; k++) begin
            set_random_tx(0);
            run_seq("round_trip", 1, 1'b0);
        end

        repeat (3) @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL outstanding: %0d results never delivered, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
